blk_ad5f87: RTL and testbench
=============================

Name: weight_loader_wq_weight_mmap_m_axi_read_beat_tracker

Overview:
- Read-data stage directly downstream of the m_axi burst converter.
- Consumes the converter's CTRL stream and one {info, len} entry per issued burst, then counts AXI R-channel beats against it.
- Forwards data to the user side with a request-level LAST flag.
- Flags protocol/response errors as sticky bits for the mmap read path.

Parameters:
DATA_WIDTH, 32, R data width in bits
CTRL_DEPTH, 16, ctrl FIFO entries (power of 2, >=2)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
clk_en  in  1  global clock enable; all state holds when low
in_CTRL_INFO  in  1  burst is last burst of user request
in_CTRL_LEN  in  8  burst length minus 1 (AXI ARLEN encoding)
in_CTRL_VALID  in  1  ctrl entry valid
out_CTRL_READY  out  1  ctrl FIFO can accept
in_R_DATA  in  DATA_WIDTH  AXI read data
in_R_RESP  in  2  AXI RRESP
in_R_LAST  in  1  AXI RLAST
in_R_VALID  in  1  R beat valid
out_R_READY  out  1  R beat accept
out_DATA  out  DATA_WIDTH  user data
out_DATA_LAST  out  1  final beat of user request
out_DATA_VALID  out  1  user data valid
in_DATA_READY  in  1  user accept
out_ERR  out  2  sticky: [0] RLAST mismatch, [1] RRESP != OKAY

Behaviour:
- Interface clock and reset: clock clk; reset reset, synchronous, active-high.
- Reset values:
  - ctrl FIFO empty.
  - beat_cnt=0.
  - out_DATA_VALID=0, out_DATA_LAST=0, out_DATA=0.
  - out_ERR=0.
  - out_CTRL_READY=0 during reset, 1 on the first cycle after reset.
- Ctrl FIFO:
  - out_CTRL_READY = ~full & clk_en. Push on in_CTRL_VALID & out_CTRL_READY.
  - A pop in the same cycle does not free space for that cycle's push. Full blocks the push.
  - Simultaneous push and pop when the FIFO is neither empty nor full keeps the count unchanged.
- Head entry (head_len, head_info) is valid when the FIFO is non-empty.
- R acceptance:
  - out_R_READY = clk_en & ~empty & (~out_DATA_VALID | in_DATA_READY).
  - An R beat with an empty FIFO stalls; it is never dropped.
- Beat counting on each R handshake:
  - burst_end = (beat_cnt == head_len).
  - If burst_end: beat_cnt <= 0 and the head is popped. Otherwise beat_cnt <= beat_cnt+1.
  - The burst boundary is set by head_len only, never by in_R_LAST.
- Output register, 1-cycle latency:
  - On an R handshake: out_DATA <= in_R_DATA, out_DATA_VALID <= 1, out_DATA_LAST <= burst_end & head_info.
  - If there is no R handshake and in_DATA_READY is high: out_DATA_VALID <= 0.
  - Full throughput: back-to-back beats with in_DATA_READY held at 1.
- Errors (sticky until reset):
  - out_ERR[0] set when in_R_LAST != burst_end on any handshake.
  - out_ERR[1] set when in_R_RESP != 0.
  - Data is still forwarded unchanged.
- Length 0 entry: single-beat burst; pops on the first beat.
- Wrap-around: FIFO pointers are log2(CTRL_DEPTH)+1 bits. Full/empty are decided by MSB compare.
- clk_en low: every register holds; both ready outputs are low; out_DATA_VALID/out_DATA are held stable.
- Reset mid-burst discards FIFO contents, the partial count and the output register. Beats arriving after reset are counted against new entries only.

Decomposition:
- Shared package: AXI RRESP encodings (OKAY=2'b00, EXOKAY, SLVERR, DECERR); ctrl entry width constant (1+8); error bit index constants.
- One sub-module: weight_loader_wq_weight_mmap_m_axi_ctrl_fifo.
  - Sync FIFO of {info, len} entries.
  - Ports: push/pop, full/empty.
  - Registered pointers, with clk_en and reset as above.
- Counter, R handshake and output register stay in the top module.

Test Plan:
- Single request, 1 ctrl {info=1,len=3}, 4 R beats D0..D3 with RLAST on D3, sink always ready -> out_DATA D0..D3 on consecutive cycles, each one cycle after its R handshake; out_DATA_LAST only on D3; out_ERR=0.
- 4KB-split request, ctrl {0,15} then {1,7}, 24 beats -> out_DATA_LAST only on beat 24; FIFO empty afterwards; out_R_READY low once the FIFO is empty.
- Backpressure: in_DATA_READY toggled 1010 during an 8-beat burst -> no beat lost or duplicated; out_DATA stable while valid & ~ready; out_R_READY follows the rule above.
- FIFO full: push 16 entries {0,0} with no R traffic -> out_CTRL_READY drops after the 16th; 1 beat in -> ready returns the next cycle; pointer wrap verified over 40 entries.
- Errors: ctrl {1,1}, beats with RLAST on beat 1 and RRESP=2 on beat 2 -> out_ERR=2'b11 sticky; data still forwarded; LAST on beat 2.
- clk_en held low 5 cycles mid-burst, then reset asserted mid-burst -> state frozen during clk_en low; after reset all outputs are 0, the FIFO is empty, and a fresh {1,0} entry plus beat yields LAST on the first beat.

Source files
------------

// File: rtl/blk_ad5f87_pkg.sv
// Shared types and constants for the m_axi read beat tracker.
// Covers RRESP encodings, the ctrl entry layout and the error bit positions.
package blk_ad5f87_pkg;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_EXOKAY = 2'b01,
      RESP_SLVERR = 2'b10,
      RESP_DECERR = 2'b11
   } rresp_e;

   localparam int CTRL_LEN_W = 8;
   localparam int CTRL_W     = 1 + CTRL_LEN_W;

   localparam int ERR_RLAST = 0;
   localparam int ERR_RESP  = 1;

   typedef struct packed {
      logic                  info;
      logic [CTRL_LEN_W-1:0] len;
   } ctrl_t;

endpackage

// File: rtl/blk_ad5f87_if.sv
// Ctrl, AXI R and user data streams of the read beat tracker.
// The slave modport is the tracker's view; master is the environment's view.
interface blk_ad5f87_if #(parameter int DATA_WIDTH = 32) ();
   import blk_ad5f87_pkg::*;

   logic                  in_CTRL_INFO;
   logic [CTRL_LEN_W-1:0] in_CTRL_LEN;
   logic                  in_CTRL_VALID;
   logic                  out_CTRL_READY;
   logic [DATA_WIDTH-1:0] in_R_DATA;
   logic [1:0]            in_R_RESP;
   logic                  in_R_LAST;
   logic                  in_R_VALID;
   logic                  out_R_READY;
   logic [DATA_WIDTH-1:0] out_DATA;
   logic                  out_DATA_LAST;
   logic                  out_DATA_VALID;
   logic                  in_DATA_READY;
   logic [1:0]            out_ERR;

   modport slave (
      input  in_CTRL_INFO, in_CTRL_LEN, in_CTRL_VALID,
      output out_CTRL_READY,
      input  in_R_DATA, in_R_RESP, in_R_LAST, in_R_VALID,
      output out_R_READY,
      output out_DATA, out_DATA_LAST, out_DATA_VALID,
      input  in_DATA_READY,
      output out_ERR
   );

   modport master (
      output in_CTRL_INFO, in_CTRL_LEN, in_CTRL_VALID,
      input  out_CTRL_READY,
      output in_R_DATA, in_R_RESP, in_R_LAST, in_R_VALID,
      input  out_R_READY,
      input  out_DATA, out_DATA_LAST, out_DATA_VALID,
      output in_DATA_READY,
      input  out_ERR
   );

endinterface

// File: rtl/blk_ad5f87_ctrl_fifo.sv
// Synchronous FIFO of {info, len} burst entries.
// Pointers carry one extra wrap bit so full and empty are told apart by the MSB.
module weight_loader_wq_weight_mmap_m_axi_ctrl_fifo
   import blk_ad5f87_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic  clk,
   input  logic  reset,
   input  logic  clk_en,
   input  logic  push,
   input  ctrl_t push_data,
   input  logic  pop,
   output ctrl_t head,
   output logic  full,
   output logic  empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0] wr_ptr, rd_ptr;
   ctrl_t       mem [DEPTH];

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign head  = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (clk_en) begin
         if (push && !full)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop && !empty)
            rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage needs no reset: an entry is only read once the pointers cover it.
   always_ff @(posedge clk) begin
      if (clk_en && push && !full)
         mem[wr_ptr[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/blk_ad5f87.sv
// Read-data beat tracker: counts R beats against queued burst lengths, forwards
// data with a request-level LAST and keeps sticky RLAST/RRESP error flags.
module blk_ad5f87
   import blk_ad5f87_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int CTRL_DEPTH = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        clk_en,
   blk_ad5f87_if.slave bus
);

   ctrl_t                 push_data, head;
   logic                  full, empty, push, pop;
   logic                  r_hs, burst_end;
   logic [CTRL_LEN_W-1:0] beat_cnt;
   logic [DATA_WIDTH-1:0] data_q;
   logic                  last_q, valid_q;
   logic [1:0]            err_q;

   assign push_data = '{info: bus.in_CTRL_INFO, len: bus.in_CTRL_LEN};

   // Ready is masked during reset; a pop never frees space for the same cycle's push.
   assign bus.out_CTRL_READY = clk_en & ~reset & ~full;
   assign push               = bus.in_CTRL_VALID & bus.out_CTRL_READY;

   assign bus.out_R_READY = clk_en & ~reset & ~empty & (~valid_q | bus.in_DATA_READY);
   assign r_hs            = bus.in_R_VALID & bus.out_R_READY;

   // Burst boundary comes from the queued length alone; RLAST is only cross-checked.
   assign burst_end = (beat_cnt == head.len);
   assign pop       = r_hs & burst_end;

   weight_loader_wq_weight_mmap_m_axi_ctrl_fifo #(.DEPTH(CTRL_DEPTH)) u_ctrl_fifo (
      .clk       (clk),
      .reset     (reset),
      .clk_en    (clk_en),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .head      (head),
      .full      (full),
      .empty     (empty)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         beat_cnt <= '0;
         data_q   <= '0;
         last_q   <= 1'b0;
         valid_q  <= 1'b0;
         err_q    <= '0;
      end else if (clk_en) begin
         if (r_hs) begin
            beat_cnt <= burst_end ? '0 : beat_cnt + 1'b1;
            data_q   <= bus.in_R_DATA;
            valid_q  <= 1'b1;
            last_q   <= burst_end & head.info;
            if (bus.in_R_LAST != burst_end)
               err_q[ERR_RLAST] <= 1'b1;
            if (bus.in_R_RESP != RESP_OKAY)
               err_q[ERR_RESP] <= 1'b1;
         end else if (bus.in_DATA_READY) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign bus.out_DATA       = data_q;
   assign bus.out_DATA_LAST  = last_q;
   assign bus.out_DATA_VALID = valid_q;
   assign bus.out_ERR        = err_q;

endmodule

// File: tb/tb_blk_ad5f87.sv
// Self-checking bench for blk_ad5f87: table-driven R beats with a scoreboard of
// expected {data, last}, plus hand-written full/clk_en/reset sequences.
module tb_blk_ad5f87;
   import blk_ad5f87_pkg::*;

   localparam int DW    = 32;
   localparam int DEPTH = 16;

   logic clk = 1'b0;
   logic reset, clk_en;

   blk_ad5f87_if #(.DATA_WIDTH(DW)) bus ();

   blk_ad5f87 #(.DATA_WIDTH(DW), .CTRL_DEPTH(DEPTH)) dut (
      .clk    (clk),
      .reset  (reset),
      .clk_en (clk_en),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] data;
      logic [1:0]    resp;
      logic          rlast;
      logic          exp_last;
   } beat_t;

   typedef struct {
      logic [DW-1:0] data;
      logic          last;
   } exp_t;

   exp_t  sb[$];
   beat_t tbl[$];
   int    total = 0;
   int    bad   = 0;
   int    sink_mode = 0;
   logic  hold_q = 1'b0;
   logic [DW-1:0] hold_data;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      total++;
      bad++;
      $display("FAIL %s: got timeout/unexpected expected normal progress", name);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_ctrl(input logic info, input logic [7:0] len);
      int n = 0;
      bus.in_CTRL_INFO  = info;
      bus.in_CTRL_LEN   = len;
      bus.in_CTRL_VALID = 1'b1;
      while (1) begin
         @(negedge clk);
         if (bus.out_CTRL_READY) begin
            tick();
            break;
         end
         if (++n > 200) begin
            fail_now("ctrl_push_timeout");
            break;
         end
         tick();
      end
      bus.in_CTRL_VALID = 1'b0;
   endtask

   // Leaves R_VALID high so consecutive calls produce back-to-back beats.
   task automatic send_beat(input beat_t b);
      int n = 0;
      bus.in_R_DATA  = b.data;
      bus.in_R_RESP  = b.resp;
      bus.in_R_LAST  = b.rlast;
      bus.in_R_VALID = 1'b1;
      while (1) begin
         @(negedge clk);
         if (bus.out_R_READY) begin
            sb.push_back('{data: b.data, last: b.exp_last});
            tick();
            chk("latency_valid", 64'(bus.out_DATA_VALID), 64'd1);
            chk("latency_data", 64'(bus.out_DATA), 64'(b.data));
            break;
         end
         if (++n > 200) begin
            fail_now("r_beat_timeout");
            break;
         end
         tick();
      end
   endtask

   task automatic run_tbl();
      foreach (tbl[i]) send_beat(tbl[i]);
      bus.in_R_VALID = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (1) begin
         @(negedge clk);
         if (sb.size() == 0 && !bus.out_DATA_VALID) break;
         if (++n > 200) begin
            fail_now("drain_timeout");
            break;
         end
      end
      tick();
   endtask

   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         if (reset) begin
            hold_q = 1'b0;
         end else begin
            if (hold_q) begin
               chk("hold_valid", 64'(bus.out_DATA_VALID), 64'd1);
               chk("hold_data", 64'(bus.out_DATA), 64'(hold_data));
            end
            if (clk_en && bus.out_DATA_VALID && bus.in_DATA_READY) begin
               if (sb.size() == 0) begin
                  fail_now("unexpected_output_beat");
               end else begin
                  e = sb.pop_front();
                  chk("out_data", 64'(bus.out_DATA), 64'(e.data));
                  chk("out_last", 64'(bus.out_DATA_LAST), 64'(e.last));
               end
            end
            if (bus.out_DATA_VALID && !bus.in_DATA_READY)
               chk("r_ready_backpressure", 64'(bus.out_R_READY), 64'd0);
            hold_q    = bus.out_DATA_VALID & ~bus.in_DATA_READY;
            hold_data = bus.out_DATA;
         end
      end
   endtask

   task automatic sink_driver();
      forever begin
         tick();
         if (sink_mode == 1) bus.in_DATA_READY = ~bus.in_DATA_READY;
         else                bus.in_DATA_READY = 1'b1;
      end
   endtask

   task automatic check_reset_state(input string tag);
      @(negedge clk);
      chk({tag, "_ctrl_ready"}, 64'(bus.out_CTRL_READY), 64'd0);
      chk({tag, "_r_ready"}, 64'(bus.out_R_READY), 64'd0);
      chk({tag, "_valid"}, 64'(bus.out_DATA_VALID), 64'd0);
      chk({tag, "_last"}, 64'(bus.out_DATA_LAST), 64'd0);
      chk({tag, "_data"}, 64'(bus.out_DATA), 64'd0);
      chk({tag, "_err"}, 64'(bus.out_ERR), 64'd0);
   endtask

   initial begin
      logic [DW-1:0] snap_data;
      logic          snap_valid;
      beat_t         b;

      reset = 1'b1;
      clk_en = 1'b1;
      bus.in_CTRL_INFO = 1'b0;
      bus.in_CTRL_LEN = '0;
      bus.in_CTRL_VALID = 1'b0;
      bus.in_R_DATA = '0;
      bus.in_R_RESP = '0;
      bus.in_R_LAST = 1'b0;
      bus.in_R_VALID = 1'b0;
      bus.in_DATA_READY = 1'b1;

      fork
         monitor();
         sink_driver();
      join_none

      tick();
      tick();
      check_reset_state("reset");
      tick();
      reset = 1'b0;
      @(negedge clk);
      chk("ctrl_ready_after_reset", 64'(bus.out_CTRL_READY), 64'd1);
      tick();

      // Single request, 4 beats
      push_ctrl(1'b1, 8'd3);
      tbl.delete();
      for (int i = 0; i < 4; i++)
         tbl.push_back('{data: 32'hD000_0000 + i, resp: 2'b00, rlast: (i == 3), exp_last: (i == 3)});
      run_tbl();
      drain();
      chk("t1_err", 64'(bus.out_ERR), 64'd0);

      // 4KB-split request: 16 + 8 beats, LAST only at the very end
      push_ctrl(1'b0, 8'd15);
      push_ctrl(1'b1, 8'd7);
      tbl.delete();
      for (int i = 0; i < 24; i++)
         tbl.push_back('{data: 32'h1000_0000 + i * 3, resp: 2'b00,
                         rlast: (i == 15 || i == 23), exp_last: (i == 23)});
      run_tbl();
      drain();
      chk("t2_r_ready_empty", 64'(bus.out_R_READY), 64'd0);
      chk("t2_err", 64'(bus.out_ERR), 64'd0);

      // Backpressure: sink toggles every cycle
      sink_mode = 1;
      push_ctrl(1'b1, 8'd7);
      tbl.delete();
      for (int i = 0; i < 8; i++)
         tbl.push_back('{data: 32'hBB00_0000 + i, resp: 2'b00, rlast: (i == 7), exp_last: (i == 7)});
      run_tbl();
      drain();
      sink_mode = 0;
      tick();
      chk("t3_err", 64'(bus.out_ERR), 64'd0);

      // FIFO full, then pointer wrap over 40 entries total
      for (int i = 0; i < 16; i++) push_ctrl(1'b0, 8'd0);
      bus.in_R_DATA = 32'hF000_0000;
      bus.in_R_RESP = 2'b00;
      bus.in_R_LAST = 1'b1;
      bus.in_R_VALID = 1'b1;
      @(negedge clk);
      chk("full_ctrl_ready", 64'(bus.out_CTRL_READY), 64'd0);
      chk("full_r_ready", 64'(bus.out_R_READY), 64'd1);
      sb.push_back('{data: 32'hF000_0000, last: 1'b0});
      tick();
      bus.in_R_VALID = 1'b0;
      @(negedge clk);
      chk("full_ready_returns", 64'(bus.out_CTRL_READY), 64'd1);
      tick();
      tbl.delete();
      for (int i = 1; i < 16; i++)
         tbl.push_back('{data: 32'hF000_0000 + i, resp: 2'b00, rlast: 1'b1, exp_last: 1'b0});
      run_tbl();
      for (int i = 0; i < 24; i++) begin
         push_ctrl((i == 23), 8'd0);
         b = '{data: 32'hCC00_0000 + i, resp: 2'b00, rlast: 1'b1, exp_last: (i == 23)};
         send_beat(b);
         bus.in_R_VALID = 1'b0;
      end
      drain();
      chk("wrap_r_ready_empty", 64'(bus.out_R_READY), 64'd0);
      chk("wrap_err", 64'(bus.out_ERR), 64'd0);

      // Errors: early RLAST on beat 1, SLVERR on beat 2
      push_ctrl(1'b1, 8'd1);
      tbl.delete();
      tbl.push_back('{data: 32'hE000_0001, resp: 2'b00, rlast: 1'b1, exp_last: 1'b0});
      tbl.push_back('{data: 32'hE000_0002, resp: 2'b10, rlast: 1'b0, exp_last: 1'b1});
      run_tbl();
      drain();
      chk("err_both", 64'(bus.out_ERR), 64'd3);
      push_ctrl(1'b1, 8'd0);
      tbl.delete();
      tbl.push_back('{data: 32'hE000_0003, resp: 2'b00, rlast: 1'b1, exp_last: 1'b1});
      run_tbl();
      drain();
      chk("err_sticky", 64'(bus.out_ERR), 64'd3);

      // clk_en low mid-burst, then reset mid-burst
      push_ctrl(1'b1, 8'd3);
      send_beat('{data: 32'hA5A5_0000, resp: 2'b00, rlast: 1'b0, exp_last: 1'b0});
      send_beat('{data: 32'hA5A5_0001, resp: 2'b00, rlast: 1'b0, exp_last: 1'b0});
      bus.in_R_DATA = 32'hA5A5_0002;
      clk_en = 1'b0;
      snap_data  = bus.out_DATA;
      snap_valid = bus.out_DATA_VALID;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("frz_r_ready", 64'(bus.out_R_READY), 64'd0);
         chk("frz_ctrl_ready", 64'(bus.out_CTRL_READY), 64'd0);
         chk("frz_data", 64'(bus.out_DATA), 64'(snap_data));
         chk("frz_valid", 64'(bus.out_DATA_VALID), 64'(snap_valid));
         tick();
      end
      clk_en = 1'b1;
      send_beat('{data: 32'hA5A5_0002, resp: 2'b00, rlast: 1'b0, exp_last: 1'b0});
      bus.in_R_VALID = 1'b0;
      reset = 1'b1;
      sb.delete();
      tick();
      check_reset_state("midreset");
      tick();
      reset = 1'b0;
      @(negedge clk);
      chk("midreset_ctrl_ready", 64'(bus.out_CTRL_READY), 64'd1);
      tick();
      push_ctrl(1'b1, 8'd0);
      tbl.delete();
      tbl.push_back('{data: 32'h5EED_0001, resp: 2'b00, rlast: 1'b1, exp_last: 1'b1});
      run_tbl();
      drain();
      chk("post_reset_err", 64'(bus.out_ERR), 64'd0);
      chk("post_reset_r_ready", 64'(bus.out_R_READY), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
